// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the framed-byte-stream memory loader.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_COUNT,
        ST_DATA,
        ST_CKSUM
    } state_e;

    localparam logic [7:0] CMD_IMEM       = 8'hA0;
    localparam logic [7:0] CMD_DMEM       = 8'hA1;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/mem_loader_word_packer.sv
// Little-endian byte-to-word packer: shifts bytes in from the top and
// flags the byte that completes a word so the caller can register it.
module word_packer
    import mem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      shreg_q, shreg_d;

    // NOTE: defaults first so this combinational block can never infer a latch.
    always_comb begin
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (clear_i) begin
            idx_d   = '0;
            shreg_d = '0;
        end else if (byte_valid_i) begin
            idx_d   = idx_q + 1'b1;
            shreg_d = {byte_i, shreg_q[31:8]};
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // The completing byte lands in the top lane, earlier bytes already shifted down.
    assign word_valid_o = byte_valid_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign word_o       = {byte_i, shreg_q[31:8]};

endmodule

// File: rtl/mem_loader.sv
// Framed byte-stream loader writing 32-bit words into IMem/DMem.
// Define MEM_LOADER_CKSUM_EN to require a trailing 8-bit checksum byte per frame.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q;
    logic              tgt_dmem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        cnt_q;
    logic              imem_we_q, dmem_we_q, done_q, err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
`ifdef MEM_LOADER_CKSUM_EN
    logic [7:0]        sum_q;
`endif

    logic        word_valid;
    logic [31:0] packed_word;

    word_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (in_valid && (state_q == ST_COUNT)),
        .byte_valid_i (in_valid && (state_q == ST_DATA)),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (packed_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_CMD;
            tgt_dmem_q  <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_LOADER_CKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            // Strobes and status are single-cycle pulses.
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_CMD: if (in_valid) begin
                    if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
                        tgt_dmem_q <= (in_data == CMD_DMEM);
                        state_q    <= ST_ADDR;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                ST_ADDR: if (in_valid) begin
                    addr_q  <= ADDR_W'(in_data);
                    state_q <= ST_COUNT;
                end
                ST_COUNT: if (in_valid) begin
                    cnt_q   <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
`ifdef MEM_LOADER_CKSUM_EN
                    sum_q   <= '0;
`endif
                    state_q <= ST_DATA;
                end
                ST_DATA: if (in_valid) begin
`ifdef MEM_LOADER_CKSUM_EN
                    sum_q <= sum_q + in_data;
`endif
                    if (word_valid) begin
                        imem_we_q   <= !tgt_dmem_q;
                        dmem_we_q   <= tgt_dmem_q;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= DATA_W'(packed_word);
                        addr_q      <= addr_q + 1'b1;
                        cnt_q       <= cnt_q - 9'd1;
                        if (cnt_q == 9'd1) begin
`ifdef MEM_LOADER_CKSUM_EN
                            state_q <= ST_CKSUM;
`else
                            done_q  <= 1'b1;
                            state_q <= ST_CMD;
`endif
                        end
                    end
                end
`ifdef MEM_LOADER_CKSUM_EN
                ST_CKSUM: if (in_valid) begin
                    done_q  <= (in_data == sum_q);
                    err_q   <= (in_data != sum_q);
                    state_q <= ST_CMD;
                end
`endif
                default: state_q <= ST_CMD;
            endcase
        end
    end

    assign in_ready  = 1'b1;
    assign busy      = (state_q != ST_CMD);
    assign imem_we   = imem_we_q;
    assign dmem_we   = dmem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
